// File: rtl/shot_clock_ctrl.sv
// Purpose : game shot clock; counts down once per TICKS_PER_SEC cycles, buzzes on expiry.
// Latency : 1 cycle from any sampled input to count/buzz/running (all registered).
// Backpressure: none; level controls are applied every edge in priority order.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      level; begin or resume countdown (IDLE/PAUSE -> RUN when count>0)
//   stop       level; pause countdown (RUN -> PAUSE, prescaler held)
//   shoot      level; reload count to FULL_VAL, clear prescaler and buzz
//   short_rst  level; raise count to SHORT_VAL if below it, clear prescaler
//   count      current shot-clock value
//   buzz       expiry buzzer, high for BUZZ_CYCLES cycles
//   running    high while counting down
module shot_clock_ctrl #(
    parameter int WIDTH         = 5,
    parameter int FULL_VAL      = 24,
    parameter int SHORT_VAL     = 14,
    parameter int TICKS_PER_SEC = 10,
    parameter int BUZZ_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             shoot,
    input  logic             short_rst,
    output logic [WIDTH-1:0] count,
    output logic             buzz,
    output logic             running
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    localparam logic [WIDTH-1:0] FULL       = WIDTH'(FULL_VAL);
    localparam logic [WIDTH-1:0] SHORT      = WIDTH'(SHORT_VAL);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO   = WIDTH'(0);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0]    PRESC_ZERO = PW'(0);
    localparam logic [BW-1:0]    BUZZ_LAST  = BW'(BUZZ_CYCLES - 1);
    localparam logic [BW-1:0]    BCNT_ONE   = BW'(1);
    localparam logic [BW-1:0]    BCNT_ZERO  = BW'(0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              buzz_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count   <= FULL;
            presc_q <= PRESC_ZERO;
            bcnt_q  <= BCNT_ZERO;
            buzz    <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            count   <= count_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            buzz    <= buzz_d;
            running <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count;
        presc_d = presc_q;
        bcnt_d  = bcnt_q;
        buzz_d  = buzz;

        if (shoot) begin
            count_d = FULL;
            presc_d = PRESC_ZERO;
            bcnt_d  = BCNT_ZERO;
            buzz_d  = 1'b0;
            if (state_q == EXPIRED) begin
                state_d = IDLE;
            end
        end else if (short_rst) begin
            if (count < SHORT) begin
                count_d = SHORT;
            end
            presc_d = PRESC_ZERO;
            if (state_q == EXPIRED) begin
                state_d = IDLE;
                bcnt_d  = BCNT_ZERO;
                buzz_d  = 1'b0;
            end
        end else begin
            case (state_q)
                // stop outranks start, so holding both keeps the clock parked
                IDLE, PAUSE: begin
                    if (!stop && start && (count != CNT_ZERO)) begin
                        state_d = RUN;
                    end
                end
                // start while already running is a no-op, so the tick still applies
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = PRESC_ZERO;
                        if (count != CNT_ZERO) begin
                            count_d = count - CNT_ONE;
                        end
                        if (count <= CNT_ONE) begin
                            state_d = EXPIRED;
                            buzz_d  = 1'b1;
                            bcnt_d  = BCNT_ZERO;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
                // buzzer timing runs regardless of stop/start so it always ends
                EXPIRED: begin
                    if (bcnt_q == BUZZ_LAST) begin
                        bcnt_d  = BCNT_ZERO;
                        buzz_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
module tb_shot_clock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       shoot;
    logic       short_rst;
    logic [4:0] count;
    logic       buzz;
    logic       running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] c;
        logic       b;
        logic       r;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    shot_clock_ctrl #(
        .WIDTH        (5),
        .FULL_VAL     (24),
        .SHORT_VAL    (14),
        .TICKS_PER_SEC(4),
        .BUZZ_CYCLES  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .shoot    (shoot),
        .short_rst(short_rst),
        .count    (count),
        .buzz     (buzz),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic st, input logic sp, input logic sh, input logic sr);
        start     = st;
        stop      = sp;
        shoot     = sh;
        short_rst = sr;
    endtask

    task automatic push(input int c, input logic b, input logic r);
        exp_t x;
        x.c = 5'(c);
        x.b = b;
        x.r = r;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        push(24, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
            errors++;
            $display("FAIL reset: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                     count, buzz, running, e.c, e.b, e.r);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(24, 0, 0);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL post_reset_idle: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
    endtask

    // full countdown from 24 with one start pulse, then buzz and idle
    task automatic test_countdown();
        set_in(1, 0, 0, 0);
        push(24, 0, 1);
        cyc();
        set_in(0, 0, 0, 0);
        for (int i = 1; i <= 99; i++) begin
            push((i < 96) ? 24 - i / 4 : 0, (i >= 96 && i <= 98), (i < 96));
        end
        e = exp_q.pop_front();
        checks++;
        if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
            errors++;
            $display("FAIL countdown_start: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                     count, buzz, running, e.c, e.b, e.r);
        end
        while (exp_q.size() > 0) begin
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL countdown: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
    endtask

    task automatic test_start_zero();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0);
            push(0, 0, 0);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL start_zero: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
        set_in(0, 0, 0, 0);
    endtask

    // pause with prescaler at 2; after resume the tick comes 2 cycles later
    task automatic test_stop();
        exp_t stim[$];
        logic [3:0] cmd[$];
        cmd.push_back(4'b0010); push(24, 0, 0);
        cmd.push_back(4'b1000); push(24, 0, 1);
        for (int i = 1; i <= 18; i++) begin
            cmd.push_back(4'b0000); push(24 - i / 4, 0, 1);
        end
        for (int i = 0; i < 6; i++) begin
            cmd.push_back(4'b0100); push(20, 0, 0);
        end
        cmd.push_back(4'b1000); push(20, 0, 1);
        cmd.push_back(4'b0000); push(20, 0, 1);
        cmd.push_back(4'b0000); push(19, 0, 1);
        while (cmd.size() > 0) begin
            logic [3:0] c;
            c = cmd.pop_front();
            set_in(c[3], c[2], c[1], c[0]);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL stop_pause: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
        set_in(0, 0, 0, 0);
    endtask

    // running from 19 with prescaler 0: shoot at 5, then shoot during buzz
    task automatic test_shoot();
        logic [3:0] cmd[$];
        for (int i = 1; i <= 56; i++) begin
            cmd.push_back(4'b0000); push(19 - i / 4, 0, 1);
        end
        cmd.push_back(4'b0010); push(24, 0, 1);
        for (int i = 1; i <= 96; i++) begin
            cmd.push_back(4'b0000); push((i < 96) ? 24 - i / 4 : 0, (i == 96), (i < 96));
        end
        cmd.push_back(4'b0000); push(0, 1, 0);
        cmd.push_back(4'b0010); push(24, 0, 0);
        cmd.push_back(4'b0000); push(24, 0, 0);
        while (cmd.size() > 0) begin
            logic [3:0] c;
            c = cmd.pop_front();
            set_in(c[3], c[2], c[1], c[0]);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL shoot: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
        set_in(0, 0, 0, 0);
    endtask

    task automatic test_short_rst();
        logic [3:0] cmd[$];
        cmd.push_back(4'b1000); push(24, 0, 1);
        for (int i = 1; i <= 60; i++) begin
            cmd.push_back(4'b0000); push(24 - i / 4, 0, 1);
        end
        cmd.push_back(4'b0001); push(14, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            cmd.push_back(4'b0000); push(14 - i / 4, 0, 1);
        end
        cmd.push_back(4'b0010); push(24, 0, 1);
        for (int i = 1; i <= 24; i++) begin
            cmd.push_back(4'b0000); push(24 - i / 4, 0, 1);
        end
        cmd.push_back(4'b0001); push(18, 0, 1);
        cmd.push_back(4'b0000); push(18, 0, 1);
        cmd.push_back(4'b0011); push(24, 0, 1);
        cmd.push_back(4'b0100); push(24, 0, 0);
        while (cmd.size() > 0) begin
            logic [3:0] c;
            c = cmd.pop_front();
            set_in(c[3], c[2], c[1], c[0]);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL short_rst: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
        set_in(0, 0, 0, 0);
    endtask

    // resume from PAUSE at 24, expire, then assert reset between edges mid-buzz
    task automatic test_async_reset();
        logic [3:0] cmd[$];
        cmd.push_back(4'b1000); push(24, 0, 1);
        for (int i = 1; i <= 96; i++) begin
            cmd.push_back(4'b0000); push((i < 96) ? 24 - i / 4 : 0, (i == 96), (i < 96));
        end
        cmd.push_back(4'b0000); push(0, 1, 0);
        while (cmd.size() > 0) begin
            logic [3:0] c;
            c = cmd.pop_front();
            set_in(c[3], c[2], c[1], c[0]);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL pre_reset_buzz: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
        set_in(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        push(24, 0, 0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
            errors++;
            $display("FAIL async_reset: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                     count, buzz, running, e.c, e.b, e.r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(24, 0, 0);
            cyc();
            e = exp_q.pop_front();
            checks++;
            if ({count, buzz, running} !== {e.c, e.b, e.r}) begin
                errors++;
                $display("FAIL after_async_reset: got count=%0d buzz=%b running=%b want count=%0d buzz=%b running=%b",
                         count, buzz, running, e.c, e.b, e.r);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        test_reset();
        test_countdown();
        test_start_zero();
        test_stop();
        test_shoot();
        test_short_rst();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
